vend_txn_ctrl: RTL and testbench

Transaction controller for the vending machine. It sits between the edge-pulsed button/coin inputs and the dispense/coin-return hardware. It accumulates inserted credit, latches the selected price, and arbitrates confirm against return. It sequences the product dispense, then pays out change greedily with one coin pulse at a time, and reports completion with a `finish` pulse.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_txn_ctrl_change_picker.sv | 30 +++
 rtl/vend_txn_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DENOM_1  = 1;
    localparam int DENOM_2  = 2;
    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;

    localparam int DEF_CREDIT_W   = 8;
    localparam int DEF_MAX_CREDIT = 99;

    // One-hot denomination select, bit order {10, 5, 2, 1}
    typedef logic [3:0] denom_sel_t;

    function automatic logic [4:0] coin_sum(input logic c1, input logic c2,
                                            input logic c5, input logic c10);
        coin_sum = (c1  ? 5'(DENOM_1)  : 5'd0)
                 + (c2  ? 5'(DENOM_2)  : 5'd0)
                 + (c5  ? 5'(DENOM_5)  : 5'd0)
                 + (c10 ? 5'(DENOM_10) : 5'd0);
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_change_picker.sv
// Greedy change selector: largest denomination not exceeding the credit.
module change_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = DEF_CREDIT_W
) (
    input  logic [CREDIT_W-1:0] credit,
    output denom_sel_t          denom_sel,
    output logic [CREDIT_W-1:0] denom_val
);

    always_comb begin
        denom_sel = '0;
        denom_val = '0;
        if (credit >= CREDIT_W'(DENOM_10)) begin
            denom_sel = 4'b1000;
            denom_val = CREDIT_W'(DENOM_10);
        end else if (credit >= CREDIT_W'(DENOM_5)) begin
            denom_sel = 4'b0100;
            denom_val = CREDIT_W'(DENOM_5);
        end else if (credit >= CREDIT_W'(DENOM_2)) begin
            denom_sel = 4'b0010;
            denom_val = CREDIT_W'(DENOM_2);
        end else if (credit >= CREDIT_W'(DENOM_1)) begin
            denom_sel = 4'b0001;
            denom_val = CREDIT_W'(DENOM_1);
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit collection, purchase, dispense and
// greedy change payout. Every output is a register fed from next-state logic.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
    parameter int DISP_CYCLES = 4,
    parameter int CHANGE_GAP  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                coin1_p,
    input  logic                coin2_p,
    input  logic                coin5_p,
    input  logic                coin10_p,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    input  logic                confirm_p,
    input  logic                return_p,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                coin_out1,
    output logic                coin_out2,
    output logic                coin_out5,
    output logic                coin_out10,
    output logic                busy,
    output logic                finish,
    output logic                err_funds,
    output logic                reject
);

    localparam int CNT_MAX = (DISP_CYCLES - 1 > CHANGE_GAP) ? DISP_CYCLES - 1 : CHANGE_GAP;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int SUM_W   = CREDIT_W + 5;

    state_t              state, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W-1:0] price, price_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                dispense_d, finish_d, err_d, reject_d, busy_d;
    denom_sel_t          coin_out_d;
    logic                load_change;

    denom_sel_t          pick_sel;
    logic [CREDIT_W-1:0] pick_val;
    logic                any_coin;
    logic [SUM_W-1:0]    credit_sum;
    logic                coin_fits;

    change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
        .credit    (credit),
        .denom_sel (pick_sel),
        .denom_val (pick_val)
    );

    assign any_coin   = coin1_p | coin2_p | coin5_p | coin10_p;
    assign credit_sum = SUM_W'(credit) + SUM_W'(coin_sum(coin1_p, coin2_p, coin5_p, coin10_p));
    assign coin_fits  = (credit_sum <= SUM_W'(MAX_CREDIT));

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state;
        credit_d    = credit;
        price_d     = price;
        cnt_d       = cnt;
        dispense_d  = 1'b0;
        coin_out_d  = '0;
        finish_d    = 1'b0;
        err_d       = 1'b0;
        reject_d    = 1'b0;
        load_change = 1'b0;

        case (state)
            COLLECT: begin
                if (!enable) begin
                    reject_d    = any_coin;
                    load_change = (credit != '0);
                end else if (return_p && credit != '0) begin
                    reject_d    = any_coin;
                    load_change = 1'b1;
                end else begin
                    if (sel_valid)
                        price_d = sel_price;
                    // A simultaneous return always drops the confirm silently
                    if (confirm_p && !return_p) begin
                        if (price != '0 && credit >= price) begin
                            credit_d   = credit - price;
                            state_d    = DISPENSE;
                            dispense_d = 1'b1;
                            cnt_d      = CNT_W'(DISP_CYCLES - 1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // Coins arriving as the purchase starts are refused
                    if (any_coin) begin
                        if (state_d == COLLECT && coin_fits)
                            credit_d = CREDIT_W'(credit_sum);
                        else
                            reject_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_d = any_coin;
                if (cnt == '0) begin
                    if (credit != '0) begin
                        load_change = 1'b1;
                    end else begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt - 1'b1;
                    dispense_d = 1'b1;
                end
            end
            CHANGE: begin
                reject_d = any_coin;
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (credit != '0) begin
                    load_change = 1'b1;
                end else begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end
            end
            DONE: begin
                reject_d = any_coin;
                price_d  = '0;
                state_d  = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        // Entering or continuing change payout emits a coin on the same edge
        if (load_change) begin
            state_d    = CHANGE;
            coin_out_d = pick_sel;
            credit_d   = credit - pick_val;
            cnt_d      = CNT_W'(CHANGE_GAP);
        end

        busy_d = (state_d != COLLECT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            credit     <= '0;
            price      <= '0;
            cnt        <= '0;
            dispense   <= 1'b0;
            coin_out10 <= 1'b0;
            coin_out5  <= 1'b0;
            coin_out2  <= 1'b0;
            coin_out1  <= 1'b0;
            finish     <= 1'b0;
            err_funds  <= 1'b0;
            reject     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            credit     <= credit_d;
            price      <= price_d;
            cnt        <= cnt_d;
            dispense   <= dispense_d;
            coin_out10 <= coin_out_d[3];
            coin_out5  <= coin_out_d[2];
            coin_out2  <= coin_out_d[1];
            coin_out1  <= coin_out_d[0];
            finish     <= finish_d;
            err_funds  <= err_d;
            reject     <= reject_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scoreboard bench for vend_txn_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares them whenever a pulse output is active.
module tb_vend_txn_ctrl;

    localparam logic [7:0] EV_DISP = 8'h80;
    localparam logic [7:0] EV_C10  = 8'h40;
    localparam logic [7:0] EV_C5   = 8'h20;
    localparam logic [7:0] EV_C2   = 8'h10;
    localparam logic [7:0] EV_C1   = 8'h08;
    localparam logic [7:0] EV_FIN  = 8'h04;
    localparam logic [7:0] EV_ERR  = 8'h02;
    localparam logic [7:0] EV_REJ  = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       coin1_p = 1'b0, coin2_p = 1'b0, coin5_p = 1'b0, coin10_p = 1'b0;
    logic       sel_valid = 1'b0;
    logic [7:0] sel_price = 8'd0;
    logic       confirm_p = 1'b0, return_p = 1'b0;
    logic [7:0] credit;
    logic       dispense, coin_out1, coin_out2, coin_out5, coin_out10;
    logic       busy, finish, err_funds, reject;

    typedef struct {
        int         cyc;
        logic [7:0] ev;
        logic [7:0] credit;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    vend_txn_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .coin1_p    (coin1_p),
        .coin2_p    (coin2_p),
        .coin5_p    (coin5_p),
        .coin10_p   (coin10_p),
        .sel_valid  (sel_valid),
        .sel_price  (sel_price),
        .confirm_p  (confirm_p),
        .return_p   (return_p),
        .credit     (credit),
        .dispense   (dispense),
        .coin_out1  (coin_out1),
        .coin_out2  (coin_out2),
        .coin_out5  (coin_out5),
        .coin_out10 (coin_out10),
        .busy       (busy),
        .finish     (finish),
        .err_funds  (err_funds),
        .reject     (reject)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle with an active pulse output must match the queue head
    always @(negedge clk) begin
        logic [7:0] ev;
        exp_t       e;
        ev = {dispense, coin_out10, coin_out5, coin_out2, coin_out1, finish, err_funds, reject};
        if (rst_n === 1'b1 && ev != 8'h00) begin
            if (q.size() == 0) begin
                check("unexpected_evt", {32'(cyc), ev, credit}, 64'd0);
            end else begin
                e = q.pop_front();
                check("evt", {32'(cyc), ev, credit}, {32'(e.cyc), e.ev, e.credit});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of pulses; s is the cycle in which the response appears
    task automatic drive(input logic [3:0] coins, input logic sel, input logic [7:0] price,
                         input logic conf, input logic ret, output int s);
        {coin10_p, coin5_p, coin2_p, coin1_p} = coins;
        sel_valid = sel;
        sel_price = price;
        confirm_p = conf;
        return_p  = ret;
        s = cyc + 1;
        tick();
        {coin10_p, coin5_p, coin2_p, coin1_p} = 4'b0000;
        sel_valid = 1'b0;
        sel_price = 8'd0;
        confirm_p = 1'b0;
        return_p  = 1'b0;
    endtask

    task automatic push(input int c, input logic [7:0] ev, input logic [7:0] cr);
        exp_t e;
        e.cyc = c;
        e.ev = ev;
        e.credit = cr;
        q.push_back(e);
    endtask

    task automatic coin(input logic [3:0] coins, input logic [7:0] exp_credit);
        int s;
        drive(coins, 1'b0, 8'd0, 1'b0, 1'b0, s);
        check("coin_credit", credit, exp_credit);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && q.size() != 0; i++) tick();
        check("drain_left", q.size(), 0);
    endtask

    function automatic logic [63:0] outs();
        return {dispense, coin_out10, coin_out5, coin_out2, coin_out1,
                finish, err_funds, reject, busy, credit};
    endfunction

    initial begin
        int s;
        int s2;

        // Reset state
        repeat (2) tick();
        check("reset_outs", outs(), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check("post_reset", outs(), 64'd0);

        // Buy with change: 15 credit, price 12
        coin(4'b1000, 8'd10);
        coin(4'b0100, 8'd15);
        drive(4'b0000, 1'b1, 8'd12, 1'b0, 1'b0, s);
        drive(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0, s);
        for (int i = 0; i < 4; i++) push(s + i, EV_DISP, 8'd3);
        push(s + 4, EV_C2, 8'd1);
        push(s + 7, EV_C1, 8'd0);
        push(s + 10, EV_FIN, 8'd0);
        check("buy_busy", busy, 1'b1);
        wait_drain();
        check("buy_credit", credit, 8'd0);
        check("buy_idle", busy, 1'b0);

        // Insufficient funds
        coin(4'b0100, 8'd5);
        drive(4'b0000, 1'b1, 8'd7, 1'b0, 1'b0, s);
        drive(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0, s);
        push(s, EV_ERR, 8'd5);
        wait_drain();
        check("nsf_credit", credit, 8'd5);
        check("nsf_idle", busy, 1'b0);

        // Overflow with simultaneous coins
        for (int i = 0; i < 9; i++) coin(4'b1000, 8'(5 + 10 * (i + 1)));
        drive(4'b0110, 1'b0, 8'd0, 1'b0, 1'b0, s);
        push(s, EV_REJ, 8'd95);
        wait_drain();
        check("ovf_credit", credit, 8'd95);
        coin(4'b0010, 8'd97);

        // Return of 97: nine 10s, one 5, one 2
        drive(4'b0000, 1'b0, 8'd0, 1'b0, 1'b1, s);
        for (int i = 0; i < 9; i++) push(s + 3 * i, EV_C10, 8'(87 - 10 * i));
        push(s + 27, EV_C5, 8'd2);
        push(s + 30, EV_C2, 8'd0);
        push(s + 33, EV_FIN, 8'd0);
        wait_drain();
        check("ret_credit", credit, 8'd0);

        // Confirm and return together: return wins
        coin(4'b0100, 8'd5);
        coin(4'b0010, 8'd7);
        coin(4'b0001, 8'd8);
        drive(4'b0000, 1'b1, 8'd5, 1'b0, 1'b0, s);
        drive(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1, s);
        push(s, EV_C5, 8'd3);
        push(s + 3, EV_C2, 8'd1);
        push(s + 6, EV_C1, 8'd0);
        push(s + 9, EV_FIN, 8'd0);
        wait_drain();
        check("both_credit", credit, 8'd0);

        // Forced refund on enable drop, coin during CHANGE rejected
        coin(4'b1000, 8'd10);
        enable = 1'b0;
        s = cyc + 1;
        tick();
        push(s, EV_C10, 8'd0);
        drive(4'b0001, 1'b0, 8'd0, 1'b0, 1'b0, s2);
        push(s2, EV_REJ, 8'd0);
        push(s + 3, EV_FIN, 8'd0);
        wait_drain();
        enable = 1'b1;
        check("refund_idle", outs(), 64'd0);

        // Reset during the second dispense cycle
        coin(4'b1000, 8'd10);
        drive(4'b0000, 1'b1, 8'd5, 1'b0, 1'b0, s);
        drive(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0, s);
        push(s, EV_DISP, 8'd5);
        tick();
        check("disp_2nd", dispense, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 64'd0);
        check("rst_queue", q.size(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_release", outs(), 64'd0);
        coin(4'b0001, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
